// File: rtl/instruc_assemble.sv
// ---------------------------------------------------------------------------
// instruc_assemble
//
// Packs RISC-V field sets into 32-bit instruction words, tags each word with
// a sequential byte address and streams the results out through a 2-entry
// in-order FIFO. Both sides use valid/ready handshakes.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   field set presented          in_ready   block can accept
//   fmt        0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal (emit NOP, flag fmt_err)
//   opcode, rd, funct3, rs1, rs2, funct7, imm   instruction fields
//   out_valid  FIFO head valid              out_ready  consumer takes head
//   instruc    assembled word at FIFO head  addr       byte address of head
//   fmt_err    sticky: an illegal fmt was accepted since reset
// ---------------------------------------------------------------------------
module instruc_assemble #(
  parameter int unsigned          ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [2:0]        funct3,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       instruc,
  output logic [ADDR_W-1:0] addr,
  output logic              fmt_err
);

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // Storage: the head slot drives the outputs directly; the tail slot holds
  // the second entry when the FIFO is full.
  logic [1:0]        count_q,      count_d;
  logic [31:0]       head_word_q,  head_word_d;
  logic [ADDR_W-1:0] head_addr_q,  head_addr_d;
  logic [31:0]       tail_word_q,  tail_word_d;
  logic [ADDR_W-1:0] tail_addr_q,  tail_addr_d;
  logic [ADDR_W-1:0] next_addr_q,  next_addr_d;
  logic              fmt_err_q,    fmt_err_d;

  logic [31:0] packed_word;
  logic        fmt_illegal;
  logic        accept;
  logic        pop;

  // Gating with the reset pin keeps in_ready low for the whole reset window,
  // not just from the first edge after it.
  assign in_ready  = reset && (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign instruc = head_word_q;
  assign addr    = head_addr_q;
  assign fmt_err = fmt_err_q;

  // Field packing. imm[0] is never encoded for B and J: those offsets are
  // always even.
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    packed_word = NOP_WORD;
    fmt_illegal = 1'b0;
    case (fmt)
      FMT_R: packed_word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: packed_word = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S: packed_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: packed_word = {imm[12], imm[10:5], rs2, rs1, funct3,
                            imm[4:1], imm[11], opcode};
      FMT_U: packed_word = {imm[31:12], rd, opcode};
      FMT_J: packed_word = {imm[20], imm[10:1], imm[11], imm[19:12],
                            rd, opcode};
      default: fmt_illegal = 1'b1;
    endcase
  end

  always_comb begin
    count_d     = count_q;
    head_word_d = head_word_q;
    head_addr_d = head_addr_q;
    tail_word_d = tail_word_q;
    tail_addr_d = tail_addr_q;
    next_addr_d = next_addr_q;
    fmt_err_d   = fmt_err_q;

    if (accept) begin
      // Counter wraps modulo 2^ADDR_W by plain truncation.
      next_addr_d = next_addr_q + ADDR_W'(4);
      if (fmt_illegal) fmt_err_d = 1'b1;
    end

    case (count_q)
      2'd0: begin
        if (accept) begin
          head_word_d = packed_word;
          head_addr_d = next_addr_q;
          count_d     = 2'd1;
        end
      end
      2'd1: begin
        if (accept && pop) begin
          // Head leaves and the new entry replaces it; depth is unchanged.
          head_word_d = packed_word;
          head_addr_d = next_addr_q;
        end else if (accept) begin
          tail_word_d = packed_word;
          tail_addr_d = next_addr_q;
          count_d     = 2'd2;
        end else if (pop) begin
          // Head registers keep their last value while the FIFO is empty.
          count_d = 2'd0;
        end
      end
      2'd2: begin
        // in_ready is low when full, so only a pop can happen here.
        if (pop) begin
          head_word_d = tail_word_q;
          head_addr_d = tail_addr_q;
          count_d     = 2'd1;
        end
      end
      default: count_d = 2'd0;
    endcase
  end

  // NOTE: the data slots are reset along with the control state because the
  // outputs read straight from the head slot and must show zero in reset.
  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q     <= 2'd0;
      head_word_q <= '0;
      head_addr_q <= '0;
      tail_word_q <= '0;
      tail_addr_q <= '0;
      next_addr_q <= BASE_ADDR;
      fmt_err_q   <= 1'b0;
    end else begin
      count_q     <= count_d;
      head_word_q <= head_word_d;
      head_addr_q <= head_addr_d;
      tail_word_q <= tail_word_d;
      tail_addr_q <= tail_addr_d;
      next_addr_q <= next_addr_d;
      fmt_err_q   <= fmt_err_d;
    end
  end

endmodule

// File: tb/tb_instruc_assemble.sv
// ---------------------------------------------------------------------------
// tb_instruc_assemble
//
// Scoreboard bench for instruc_assemble. The driver pushes the hand-computed
// word plus the modelled address whenever an accept is observed; monitors
// pop and compare whenever a head is consumed. A second instance with
// ADDR_W=4, BASE_ADDR=0xC exercises address wrap.
// ---------------------------------------------------------------------------
module tb_instruc_assemble;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [31:0] word;
  } vec_t;

  typedef struct {
    logic [31:0] word;
    logic [31:0] addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0, in_valid_w = 1'b0;
  logic        out_ready = 1'b0, out_ready_w = 1'b0;
  logic [2:0]  fmt = '0;
  logic [6:0]  opcode = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [31:0] imm = '0;

  logic        in_ready, out_valid, fmt_err;
  logic [31:0] instruc, addr;
  logic        in_ready_w, out_valid_w, fmt_err_w;
  logic [31:0] instruc_w;
  logic [3:0]  addr_w;

  exp_t        sb_q[$];
  exp_t        sbw_q[$];
  logic [31:0] exp_addr  = 32'h0;
  logic [3:0]  exp_addr_w = 4'hC;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instruc_assemble u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1),
    .rs2(rs2), .funct7(funct7), .imm(imm), .out_valid(out_valid),
    .out_ready(out_ready), .instruc(instruc), .addr(addr), .fmt_err(fmt_err)
  );

  instruc_assemble #(.ADDR_W(4), .BASE_ADDR(4'hC)) u_wrap (
    .clk(clk), .reset(reset), .in_valid(in_valid_w), .in_ready(in_ready_w),
    .fmt(fmt), .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1),
    .rs2(rs2), .funct7(funct7), .imm(imm), .out_valid(out_valid_w),
    .out_ready(out_ready_w), .instruc(instruc_w), .addr(addr_w),
    .fmt_err(fmt_err_w)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitors: compare the head on every cycle it is consumed.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_out", 32'h1, 32'h0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("instruc", instruc, e.word);
        check("addr", addr, e.addr);
      end
    end
  end

  always @(negedge clk) begin
    if (reset && out_valid_w && out_ready_w) begin
      if (sbw_q.size() == 0) begin
        check("wrap_unexpected_out", 32'h1, 32'h0);
      end else begin
        exp_t e;
        e = sbw_q.pop_front();
        check("wrap_instruc", instruc_w, e.word);
        check("wrap_addr", {28'h0, addr_w}, e.addr);
      end
    end
  end

  task automatic drive_fields(input vec_t v);
    fmt = v.fmt; opcode = v.opcode; rd = v.rd; funct3 = v.funct3;
    rs1 = v.rs1; rs2 = v.rs2; funct7 = v.funct7; imm = v.imm;
  endtask

  // Present one field set to the selected instance until it is accepted.
  // Entered and left #1 after a rising edge.
  task automatic send(input vec_t v, input bit to_wrap);
    bit accepted = 1'b0;
    drive_fields(v);
    if (to_wrap) in_valid_w = 1'b1; else in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (to_wrap ? in_ready_w : in_ready) begin
        accepted = 1'b1;
        if (to_wrap) begin
          sbw_q.push_back('{word: v.word, addr: {28'h0, exp_addr_w}});
          exp_addr_w = exp_addr_w + 4'd4;
        end else begin
          sb_q.push_back('{word: v.word, addr: exp_addr});
          exp_addr = exp_addr + 32'd4;
        end
      end
      @(posedge clk); #1;
      if (accepted) break;
    end
    in_valid = 1'b0;
    in_valid_w = 1'b0;
    check("send_accepted", {31'h0, accepted}, 32'h1);
  endtask

  task automatic wait_drain();
    bit empty = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (sb_q.size() == 0 && sbw_q.size() == 0) begin
        empty = 1'b1;
        break;
      end
    end
    check("drain_done", {31'h0, empty}, 32'h1);
  endtask

  //                 fmt   op      rd     f3    rs1    rs2    f7      imm            word
  localparam vec_t V_ADD  = '{3'd0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h00, 32'h0,        32'h002081B3};
  localparam vec_t V_ADDI = '{3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'h5,        32'h00500093};
  localparam vec_t V_SW   = '{3'd2, 7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'h00, 32'h8,        32'h0020A423};
  localparam vec_t V_BEQ  = '{3'd3, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'hFFFFFFFC, 32'hFE000EE3};
  localparam vec_t V_LUI  = '{3'd4, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'h00, 32'h12345000, 32'h123452B7};
  localparam vec_t V_JAL  = '{3'd5, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'h8,        32'h008000EF};
  localparam vec_t V_ADD2 = '{3'd0, 7'h33, 5'd4, 3'd0, 5'd5, 5'd6, 7'h00, 32'h0,        32'h00628233};
  localparam vec_t V_SUB  = '{3'd0, 7'h33, 5'd7, 3'd0, 5'd8, 5'd9, 7'h20, 32'h0,        32'h409403B3};
  localparam vec_t V_ILL  = '{3'd7, 7'h7F, 5'd9, 3'd5, 5'd3, 5'd4, 7'h55, 32'hDEADBEEF, 32'h00000013};

  initial begin
    vec_t bp_vecs[4];
    int   bp_idx;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_instruc", instruc, 32'h0);
    check("rst_addr", addr, 32'h0);
    check("rst_fmt_err", {31'h0, fmt_err}, 32'h0);
    check("rst_in_ready", {31'h0, in_ready}, 32'h0);
    check("rst_wrap_in_ready", {31'h0, in_ready_w}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("post_rst_in_ready", {31'h0, in_ready}, 32'h1);
    @(posedge clk); #1;

    // Single R-type with one-cycle latency.
    out_ready = 1'b1;
    send(V_ADD, 1'b0);
    check("latency_out_valid", {31'h0, out_valid}, 32'h1);
    wait_drain();

    // Back-to-back stream, then branch/upper/jump formats.
    send(V_ADDI, 1'b0);
    send(V_SW, 1'b0);
    send(V_BEQ, 1'b0);
    send(V_LUI, 1'b0);
    send(V_JAL, 1'b0);
    wait_drain();
    check("empty_out_valid", {31'h0, out_valid}, 32'h0);
    check("empty_holds_instruc", instruc, V_JAL.word);

    // Backpressure: four cycles of offers against a stalled consumer.
    out_ready = 1'b0;
    bp_vecs = '{V_ADD2, V_SUB, V_ADDI, V_SW};
    bp_idx = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      drive_fields(bp_vecs[bp_idx]);
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back('{word: bp_vecs[bp_idx].word, addr: exp_addr});
        exp_addr = exp_addr + 32'd4;
        bp_idx++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("bp_accepts", bp_idx, 32'd2);
    check("bp_in_ready", {31'h0, in_ready}, 32'h0);
    check("bp_out_valid", {31'h0, out_valid}, 32'h1);
    check("bp_head_word", instruc, V_ADD2.word);
    check("bp_head_addr", addr, exp_addr - 32'd8);
    out_ready = 1'b1;
    wait_drain();

    // Illegal format: NOP, sticky flag, address still advances.
    send(V_ILL, 1'b0);
    check("fmt_err_set", {31'h0, fmt_err}, 32'h1);
    send(V_ADDI, 1'b0);
    check("fmt_err_sticky", {31'h0, fmt_err}, 32'h1);
    wait_drain();

    // Reset mid-stream with two entries pending.
    out_ready = 1'b0;
    send(V_LUI, 1'b0);
    send(V_JAL, 1'b0);
    reset = 1'b0;
    sb_q.delete();
    exp_addr = 32'h0;
    exp_addr_w = 4'hC;
    #1;
    check("midrst_out_valid", {31'h0, out_valid}, 32'h0);
    check("midrst_fmt_err", {31'h0, fmt_err}, 32'h0);
    check("midrst_in_ready", {31'h0, in_ready}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    out_ready = 1'b1;
    send(V_ADD, 1'b0);
    wait_drain();

    // Narrow counter wraps from 0xC to 0x0.
    out_ready_w = 1'b1;
    send(V_ADDI, 1'b1);
    send(V_SW, 1'b1);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instruc_assemble.md
Name: instruc_assemble

Overview:
Encoder counterpart of the instruction field parser. It accepts RISC-V field sets (opcode, rd, funct3, rs1, rs2, funct7, immediate) plus a format select. It packs each set into a 32-bit instruction word and tags the word with a sequential byte address. Results stream out through a 2-entry output FIFO with valid/ready handshakes on both sides. The block feeds the instruction-memory loader and the parser-vs-encoder self-check benches.

Parameters:
ADDR_W, 32, width of the emitted byte address
BASE_ADDR, 0, address tagged on the first instruction after reset (must be a multiple of 4)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  field set presented
in_ready  output  1  block can accept a field set
fmt  input  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6/7 illegal
opcode  input  7  instruction[6:0]
rd  input  5  destination register
funct3  input  3  funct3 field
rs1  input  5  source register 1
rs2  input  5  source register 2
funct7  input  7  funct7 field (R only)
imm  input  32  immediate, sign already applied by the source
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer accepts head
instruc  output  32  assembled instruction at FIFO head
addr  output  ADDR_W  byte address of the head instruction
fmt_err  output  1  sticky flag: an illegal fmt was accepted

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. While reset=0: FIFO emptied, out_valid=0, instruc=0, addr=0, fmt_err=0, in_ready=0, next-address counter=BASE_ADDR.
- After reset deasserts, in_ready = (FIFO count < 2).
- Accept rule: accept = in_valid & in_ready. Pop rule: pop = out_valid & out_ready.
- Packing (combinational, registered on accept):
  - R: {funct7, rs2, rs1, funct3, rd, opcode}.
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U: {imm[31:12], rd, opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
  - Unused imm bits are ignored, including imm[0] for B and J. Unused fields per format are ignored.
  - Illegal fmt (6 or 7): the word is 0x00000013 (NOP); fmt_err sets and stays set until reset. The address still advances.
- Address: each accepted entry captures the current counter value; the counter then increments by 4 modulo 2^ADDR_W (wraps silently).
- FIFO: 2 entries, in-order. Latency is 1 cycle: an entry accepted at edge k into an empty FIFO gives out_valid=1 after edge k. instruc and addr hold stable while out_valid=1 and out_ready=0.
- Count 1 with simultaneous accept and pop: count stays 1 and the new entry becomes head on the next cycle.
- Count 2: in_ready=0 and no accept occurs, even when a pop happens that cycle. in_ready rises the cycle after the pop.
- Count 0: out_valid=0 and instruc/addr hold their last values.
- Reset mid-stream: all pending entries are discarded and the counter returns to BASE_ADDR. The first post-reset instruction is tagged BASE_ADDR.

Test Plan:
- R add x3,x1,x2 (fmt0, op 0x33, rd3, f3 0, rs1 1, rs2 2, f7 0), out_ready=1 -> instruc=0x002081B3, addr=0x0, out_valid one cycle after accept.
- Stream with out_ready=1:
  - I addi x1,x0,5 (op 0x13, imm 5) -> 0x00500093.
  - S sw x2,8(x1) (op 0x23, f3 2, rs1 1, rs2 2, imm 8) -> 0x0020A423.
  - Addresses are 0x0 and 0x4.
- Branch/jump/upper:
  - B beq x0,x0,-4 (op 0x63, imm 0xFFFFFFFC) -> 0xFE000EE3.
  - U lui x5,0x12345 (op 0x37, imm 0x12345000) -> 0x123452B7.
  - J jal x1,8 (op 0x6F, imm 8) -> 0x008000EF.
- Backpressure: out_ready=0, in_valid=1 for 4 cycles -> exactly 2 accepts, then in_ready=0 and the head holds the first word. Raise out_ready -> remaining entries drain in order with addresses continuous.
- Illegal fmt=7 -> instruc=0x00000013, fmt_err=1 and stays 1 across later legal entries. Pull reset low mid-stream -> out_valid=0, fmt_err=0, next accepted entry tagged BASE_ADDR.
- ADDR_W=4, BASE_ADDR=0xC: two accepts -> addr 0xC, then 0x0 (wrap).
